// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: clock filter, 11-bit frame decode, E0/F0 prefix merge, event FIFO, hotkey levels.
// Latency: event visible on evt_valid 2 clocks after the stop-bit edge clock (empty FIFO).
// Backpressure: evt_valid/evt_ready; a full FIFO drops new events and sets sticky ovf. Option: PS2_ERRCNT_EN adds err_cnt.

module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             rd_fire, wr_fire;

    assign level   = wr_q - rd_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign rd_vld  = (level != '0);
    assign rd_fire = rd_rdy & rd_vld;
    // A write into a full FIFO is accepted only when a read frees a slot in the same clock.
    assign wr_fire = wr_vld & (~full | rd_fire);
    assign rd_dat  = rd_vld ? mem[rd_q[AW-1:0]] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_fire) wr_q <= wr_q + 1'b1;
            if (rd_fire) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_q[AW-1:0]] <= wr_dat;
    end
endmodule

module ps2_kbd_fifo #(
    parameter int FILTER  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [1:0]                 ps2,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [9:0]                 evt_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic                       frame_err,
    output logic                       reset_req,
    output logic                       boot_req,
    output logic                       video,
    output logic                       f12,
    output logic                       f11,
    output logic                       f8,
    output logic                       f7,
    output logic                       f6
`ifdef PS2_ERRCNT_EN
    ,
    output logic [7:0]                 err_cnt
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    // ---------------- clock filter ----------------
    logic [FILTER-1:0] sr_q, sr_d;
    logic              lvl_q, data_q, fall;

    assign sr_d = {sr_q[FILTER-2:0], ps2[0]};
    assign fall = ce & lvl_q & ~|sr_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr_q   <= '1;
            lvl_q  <= 1'b1;
            data_q <= 1'b1;
        end else if (ce) begin
            sr_q   <= sr_d;
            data_q <= ps2[1];
            if (&sr_d)       lvl_q <= 1'b1;
            else if (~|sr_d) lvl_q <= 1'b0;
        end
    end

    // ---------------- timeout counter ----------------
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TMO_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        tmo_q <= '0;
        else if (ce) begin
            if (fall)          tmo_q <= '0;
            else if (!tmo_hit) tmo_q <= tmo_q + 1'b1;
        end
    end

    // ---------------- frame receiver ----------------
    rx_state_t  state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shf_q, shf_d;
    logic       par_q, par_d;
    logic       acc_q, acc_d;
    logic       err_q, err_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            shf_q   <= '0;
            par_q   <= 1'b0;
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shf_q   <= shf_d;
            par_q   <= par_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shf_d   = shf_q;
        par_d   = par_q;
        acc_d   = 1'b0;
        err_d   = 1'b0;
        if (ce && state_q != S_IDLE && tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!data_q) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    shf_d = {data_q, shf_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = (^shf_q) ^ data_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (data_q && par_q) acc_d = 1'b1;
                    else                 err_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign frame_err = err_q;

    // ---------------- prefix decoder ----------------
    logic ext_q, brk_q, push;

    // shf_q still holds the accepted byte while acc_q is high: the receiver sits in IDLE.
    assign push = acc_q && (shf_q != 8'hE0) && (shf_q != 8'hF0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (err_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (acc_q) begin
            if (shf_q == 8'hE0)      ext_q <= 1'b1;
            else if (shf_q == 8'hF0) brk_q <= 1'b1;
            else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // ---------------- hotkey levels (active-low) ----------------
    logic ctrl_n, alt_n, del_n, bksp_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_n <= 1'b1;
            alt_n  <= 1'b1;
            del_n  <= 1'b1;
            bksp_n <= 1'b1;
            video  <= 1'b1;
            f12    <= 1'b1;
            f11    <= 1'b1;
            f8     <= 1'b1;
            f7     <= 1'b1;
            f6     <= 1'b1;
        end else if (push) begin
            unique case (shf_q)
                8'h14: ctrl_n <= brk_q;
                8'h11: alt_n  <= brk_q;
                8'h71: del_n  <= brk_q;
                8'h66: bksp_n <= brk_q;
                8'h7E: video  <= brk_q;
                8'h07: f12    <= brk_q;
                8'h78: f11    <= brk_q;
                8'h0A: f8     <= brk_q;
                8'h83: f7     <= brk_q;
                8'h0B: f6     <= brk_q;
                default: ;
            endcase
        end
    end

    assign reset_req = ctrl_n | alt_n | del_n;
    assign boot_req  = ctrl_n | alt_n | bksp_n;

    // ---------------- event FIFO ----------------
    logic fifo_full, pop, drop;

    assign pop  = evt_valid & evt_ready;
    assign drop = push & fifo_full & ~pop;

    sync_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_vld (push),
        .wr_dat ({ext_q, ~brk_q, shf_q}),
        .rd_rdy (evt_ready),
        .rd_vld (evt_valid),
        .rd_dat (evt_data),
        .level  (fifo_level),
        .full   (fifo_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

`ifdef PS2_ERRCNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                        err_cnt <= '0;
        else if (ovf_clr)                  err_cnt <= '0;
        else if (err_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed bench for ps2_kbd_fifo: bit-banged PS/2 frames, hand-computed event/hotkey expectations.
module tb_ps2_kbd_fifo;
    logic       clock = 1'b0;
    logic       reset, ce, evt_ready, ovf_clr;
    logic [1:0] ps2;
    logic       evt_valid, ovf, frame_err, reset_req, boot_req, video;
    logic       f12, f11, f8, f7, f6;
    logic [9:0] evt_data;
    logic [3:0] fifo_level;
`ifdef PS2_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    always #5 clock = ~clock;

    ps2_kbd_fifo #(.FILTER(8), .DEPTH(8), .TIMEOUT(4096)) dut (
        .clock      (clock),
        .reset      (reset),
        .ce         (ce),
        .ps2        (ps2),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .frame_err  (frame_err),
        .reset_req  (reset_req),
        .boot_req   (boot_req),
        .video      (video),
        .f12        (f12),
        .f11        (f11),
        .f8         (f8),
        .f7         (f7),
        .f6         (f6)
`ifdef PS2_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always @(negedge clock) if (frame_err === 1'b1) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        ps2[1] = b;
        ps2[0] = 1'b1;
        clk_n(20);
        ps2[0] = 1'b0;
        clk_n(20);
        ps2[0] = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(1'b1);
        clk_n(10);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        clk_n(1);
        evt_ready = 1'b0;
        clk_n(1);
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        clk_n(12);
        evt_ready = 1'b0;
        clk_n(1);
    endtask

    initial begin
        logic [7:0] code;
        reset = 1'b0; ce = 1'b1; ps2 = 2'b11; evt_ready = 1'b0; ovf_clr = 1'b0;
        clk_n(3);
        reset = 1'b1;
        clk_n(2);

        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_data", 32'(evt_data), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_lvls", 32'({reset_req, boot_req, video, f12, f11, f8, f7, f6}), 32'hFF);

        // Plain make code.
        send_frame(8'h1C, 1'b0);
        check("mk_valid", 32'(evt_valid), 32'h1);
        check("mk_data", 32'(evt_data), 32'h11C);
        check("mk_level", 32'(fifo_level), 32'h1);
        pop_one();
        check("mk_pop_valid", 32'(evt_valid), 32'h0);

        // Extended break collapses to one event.
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h71, 1'b0);
        check("ebrk_level", 32'(fifo_level), 32'h1);
        check("ebrk_data", 32'(evt_data), 32'h271);
        pop_one();

        // Bad parity is dropped, next frame is clean.
        send_frame(8'h1C, 1'b1);
        check("par_err_cnt", 32'(err_seen), 32'd1);
        check("par_level0", 32'(fifo_level), 32'h0);
        send_frame(8'h32, 1'b0);
        check("par_next_level", 32'(fifo_level), 32'h1);
        check("par_next_data", 32'(evt_data), 32'h132);
        pop_one();

        // Overflow: 9 makes into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            code = 8'h15 + 8'(i);
            send_frame(code, 1'b0);
        end
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag", 32'(ovf), 32'h1);
`ifdef PS2_ERRCNT_EN
        check("errcnt_val", 32'(err_cnt), 32'd1);
`endif
        ovf_clr = 1'b1;
        clk_n(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("ovf_order", 32'(evt_data), 32'h115 + 32'(i));
            pop_one();
        end
        check("ovf_9th_absent", 32'(evt_valid), 32'h0);

        // Partial frame then silence.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        clk_n(4096 + 10);
        check("tmo_err_cnt", 32'(err_seen), 32'd2);
        check("tmo_level0", 32'(fifo_level), 32'h0);
        send_frame(8'h1C, 1'b0);
        check("tmo_next_data", 32'(evt_data), 32'h11C);
        check("tmo_next_level", 32'(fifo_level), 32'h1);
        pop_one();

        // Hotkeys.
        send_frame(8'h14, 1'b0);
        send_frame(8'h11, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h71, 1'b0);
        check("hk_reset_req", 32'(reset_req), 32'h0);
        check("hk_boot_req", 32'(boot_req), 32'h1);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h71, 1'b0);
        check("hk_reset_rel", 32'(reset_req), 32'h1);
        send_frame(8'h07, 1'b0);
        check("hk_f12", 32'(f12), 32'h0);
        send_frame(8'h66, 1'b0);
        check("hk_boot_bksp", 32'(boot_req), 32'h0);
        check("hk_level", 32'(fifo_level), 32'd6);
        check("hk_head", 32'(evt_data), 32'h114);
        pop_one();
        pop_one();
        check("hk_ext_make", 32'(evt_data), 32'h371);
        drain();

        // Asynchronous reset in the middle of a frame.
        send_frame(8'h1C, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #3 reset = 1'b0;
        #1;
        check("arst_level", 32'(fifo_level), 32'h0);
        check("arst_valid", 32'(evt_valid), 32'h0);
        check("arst_lvls", 32'({reset_req, boot_req, f12}), 32'h7);
        clk_n(2);
        reset = 1'b1;
        clk_n(2);
        send_frame(8'h1C, 1'b0);
        check("arst_next_data", 32'(evt_data), 32'h11C);
        check("arst_next_level", 32'(fifo_level), 32'h1);
        check("final_err_cnt", 32'(err_seen), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
Parametrised successor to the team's PS/2 keyboard front end. It oversamples and filters the PS/2 clock, receives 11-bit frames and decodes E0 (extended) and F0 (break) prefixes into one event per key. Events are buffered in a FIFO with a valid/ready handshake, while the hotkey level outputs (F-keys, video, reset/boot combos) are kept. It sits between the board PS/2 pins and the machine keyboard matrix logic.

Parameters:
FILTER, 8, number of consecutive identical ce-samples of the PS/2 clock needed to change its filtered level (2..16)
DEPTH, 8, FIFO depth in events; power of two, 2..64
TIMEOUT, 4096, ce-ticks without a falling edge after which a partial frame is discarded (>=16)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ce  in  1  sampling enable; all state advances only when ce=1, except FIFO read and ovf_clr, which are clock-rate
ps2  in  2  [0]=PS/2 clock, [1]=PS/2 data (raw pins)
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer accepts the head event when evt_valid=1
evt_data  out  10  {ext, make, code[7:0]} of head event
fifo_level  out  $clog2(DEPTH)+1  stored event count
ovf  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears ovf
frame_err  out  1  one-clock pulse on parity, stop-bit or timeout error
reset_req  out  1  active-low: Ctrl+Alt+Del held
boot_req  out  1  active-low: Ctrl+Alt+Backspace held
video  out  1  active-low: Scroll Lock (7E) held
f12, f11, f8, f7, f6  out  1 each  active-low levels of F12 (07), F11 (78), F8 (0A), F7 (83), F6 (0B)

Behaviour:
- Reset values: evt_valid=0, evt_data=0, fifo_level=0, ovf=0, frame_err=0; all active-low level outputs=1; filter level=1; receiver idle; prefix flags cleared.
- Filter: a FILTER-bit shift register of ps2[0] on ce. All ones gives level 1; all zeros gives level 0. A 1->0 transition is the falling edge. ps2[1] is registered on ce and sampled at the edge.
- Receiver states: IDLE, DATA (8 bits, LSB first), PARITY, STOP.
  - IDLE->DATA on an edge with data=0. A start bit of 1 is ignored.
  - PARITY: the XOR of the 8 data bits and the parity bit must equal 1 (odd parity).
  - STOP: a stop bit of 1 with good parity accepts the byte. Otherwise frame_err pulses and no byte is produced. Either way the receiver returns to IDLE.
- Timeout: a ce-tick counter clears on every edge. If it reaches TIMEOUT outside IDLE, the receiver returns to IDLE and frame_err pulses. The counter saturates in IDLE.
- Prefix decoder:
  - Byte E0 sets ext. Byte F0 sets brk.
  - Any other byte forms an event {ext, ~brk, byte}, then clears ext and brk.
  - A frame error clears ext and brk.
- Hotkeys: updated from each formed event; make drives the output 0, break drives it 1.
  - Ctrl (14) and Alt (11) are tracked with or without ext (left and right keys share one flag).
  - Del = 71 with or without ext. Backspace = 66.
  - reset_req = ctrl|alt|del. boot_req = ctrl|alt|backspace.
- FIFO:
  - Write happens the clock after the byte is accepted. If that write lands in an empty FIFO, evt_valid rises 2 clocks after the stop-bit edge clock.
  - Pop occurs on evt_valid & evt_ready. evt_ready while empty is ignored.
  - A write while full drops the event and sets ovf. Push and pop in the same clock while full are both performed, with no overflow.
  - Pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.
  - ovf_clr clears ovf; if ovf_clr and a drop occur in the same clock, ovf ends at 1.
- Reset mid-frame: the receiver, FIFO and flags return to their reset values immediately, independent of clock.

Optional Feature:
PS2_ERRCNT_EN
- Defined: adds output err_cnt (8 bits), which increments on every frame_err pulse and saturates at 255. Resets to 0 and is cleared by ovf_clr.
- Undefined: the port is absent and no counter logic exists.

Test Plan:
- Frame 1C with good parity -> evt_data=0x11C (ext=0, make=1), evt_valid=1, fifo_level=1; evt_ready for one clock -> evt_valid=0.
- Bytes E0,F0,71 -> exactly one event, 0x271 (ext=1, make=0); fifo_level=1.
- Frame 1C with bad parity, then a good frame 32 -> one frame_err pulse, then only event 0x132.
- DEPTH=8, 9 make frames with evt_ready=0 -> fifo_level=8, ovf=1, 9th event absent; ovf_clr -> ovf=0.
- 5 bits of a frame then no edges for TIMEOUT+10 ce-ticks -> frame_err pulses, then a good frame 1C decodes to 0x11C.
- Makes 14, 11, E0 71 -> reset_req=0, boot_req=1; break E0 F0 71 -> reset_req=1; make 07 -> f12=0.
